// File: rtl/y_pc_stage.sv
// ----------------------------------------------------------------------------
// y_pc_stage
//
// Program-counter stage. Holds the current fetch address and offers it to
// instruction fetch through a valid/ready handshake. It advances by 4 on every
// accepted fetch and loads taken branch/jump targets from the upstream
// next-PC mux. It also handles stalls and halt requests, and traps misaligned
// redirect targets.
//
// Parameters:
//   SIZE      PC / address width in bits
//   RESET_PC  PC value loaded on reset
//
// Ports:
//   i_clk          clock, all state updates on the rising edge
//   i_rst          synchronous active-high reset, overrides every other input
//   i_redir_pc     next-PC word from the upstream mux
//   i_redir_valid  i_redir_pc is a taken branch/jump target this cycle
//   i_stall        hold PC and handshake state
//   i_halt_req     request to stop fetching
//   i_out_ready    fetch accepts o_pc_out this cycle
//   o_pc_out       current fetch address
//   o_pc_plus4     o_pc_out + 4 (wraps), fed back to the next-PC mux
//   o_out_valid    o_pc_out is a valid fetch request
//   o_halted       stage is in HALT
//   o_fault        misaligned redirect seen, sticky until reset
//   o_fetch_count  accepted-fetch counter
//
// Build option:
//   PC_FETCH_COUNT_EN  when defined, o_fetch_count counts accepted fetches.
//                      When undefined, o_fetch_count is tied to zero and no
//                      counter register exists. The port list is identical
//                      in both builds.
// ----------------------------------------------------------------------------
module y_pc_stage #(
    parameter int unsigned     SIZE     = 32,
    parameter logic [SIZE-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [SIZE-1:0] i_redir_pc,
    input  logic            i_redir_valid,
    input  logic            i_stall,
    input  logic            i_halt_req,
    input  logic            i_out_ready,
    output logic [SIZE-1:0] o_pc_out,
    output logic [SIZE-1:0] o_pc_plus4,
    output logic            o_out_valid,
    output logic            o_halted,
    output logic            o_fault,
    output logic [31:0]     o_fetch_count
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [SIZE-1:0] r_pc;
    logic [SIZE-1:0] w_pc_nxt;
    logic [SIZE-1:0] w_pc_plus4;
    logic            w_fire;
    logic            w_misalign;

    assign w_pc_plus4  = r_pc + SIZE'(4);
    assign w_fire      = o_out_valid & i_out_ready & ~i_stall;
    // Instruction addresses must be word aligned. Any redirect to a
    // misaligned target is fatal for the stage.
    assign w_misalign  = i_redir_valid & (i_redir_pc[1:0] != 2'b00);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_misalign) begin
                    w_state_nxt = ST_FAULT;
                end else if (!i_stall) begin
                    // A redirect squashes the pending request whether or not
                    // it was accepted this cycle.
                    if (i_redir_valid) begin
                        w_pc_nxt = i_redir_pc;
                    end else if (w_fire) begin
                        w_pc_nxt = w_pc_plus4;
                    end
                    if (i_halt_req) begin
                        w_state_nxt = ST_HALT;
                    end
                end
                // When stalled, PC and state both hold and any redirect is
                // dropped. Upstream has to present the redirect again.
            end
            default: ;  // HALT and FAULT are terminal until reset
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    assign o_pc_out    = r_pc;
    assign o_pc_plus4  = w_pc_plus4;
    assign o_out_valid = (r_state == ST_RUN);
    assign o_halted    = (r_state == ST_HALT);
    assign o_fault     = (r_state == ST_FAULT);

`ifdef PC_FETCH_COUNT_EN
    logic [31:0] r_fetch_count;

    // w_fire can only be true in RUN, so the count holds in BOOT, HALT and
    // FAULT without any extra qualification.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_count <= '0;
        end else if (w_fire) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign o_fetch_count = r_fetch_count;
`else
    assign o_fetch_count = '0;
`endif

endmodule
